// File: rtl/riscv_core_rob_pkg.sv
// Shared ROB-side types and sizes for the completion/commit datapath.
package riscv_core_rob_pkg;

  localparam int SLOT_W    = 5;
  localparam int NUM_SLOTS = 1 << SLOT_W;
  localparam int XLEN      = 32;
  localparam int REG_W     = 5;

  typedef logic [SLOT_W-1:0] slot_t;
  typedef logic [XLEN-1:0]   data_t;
  typedef logic [REG_W-1:0]  reg_t;

  // ROB slot arithmetic wraps naturally at NUM_SLOTS
  function automatic slot_t slot_inc(slot_t s);
    return s + slot_t'(1);
  endfunction

endpackage

// File: rtl/riscv_core_result_buffer_ram.sv
// Slot-indexed result storage with per-slot valid bits; two write ports (A wins), async commit reads.
// Bypass read ports exist only when RESULT_BYPASS_EN is defined.
module riscv_core_result_buffer_ram
  import riscv_core_rob_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  wr_en_a,
  input  slot_t wr_slot_a,
  input  data_t wr_data_a,
  input  logic  wr_en_b,
  input  slot_t wr_slot_b,
  input  data_t wr_data_b,
  input  logic  clr_en_a,
  input  slot_t clr_slot_a,
  input  logic  clr_en_b,
  input  slot_t clr_slot_b,
  input  slot_t rd_slot_a,
  output data_t rd_data_a,
  output logic  rd_vld_a,
  input  slot_t rd_slot_b,
  output data_t rd_data_b,
  output logic  rd_vld_b
`ifdef RESULT_BYPASS_EN
  ,
  input  slot_t byp_slot [4],
  output logic  byp_vld  [4],
  output data_t byp_data [4]
`endif
);

  data_t                mem [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] valid_q;
  logic [NUM_SLOTS-1:0] valid_d;

  // Clears first, then captures: a slot reused on the same edge it retires stays valid
  always_comb begin
    valid_d = valid_q;
    if (clr_en_a) valid_d[clr_slot_a] = 1'b0;
    if (clr_en_b) valid_d[clr_slot_b] = 1'b0;
    if (wr_en_b)  valid_d[wr_slot_b]  = 1'b1;
    if (wr_en_a)  valid_d[wr_slot_a]  = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) valid_q <= '0;
    else       valid_q <= valid_d;
  end

  always_ff @(posedge clk) begin
    if (wr_en_b) mem[wr_slot_b] <= wr_data_b;
    if (wr_en_a) mem[wr_slot_a] <= wr_data_a;
  end

  assign rd_data_a = mem[rd_slot_a];
  assign rd_vld_a  = valid_q[rd_slot_a];
  assign rd_data_b = mem[rd_slot_b];
  assign rd_vld_b  = valid_q[rd_slot_b];

`ifdef RESULT_BYPASS_EN
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      byp_vld[i]  = valid_q[byp_slot[i]];
      byp_data[i] = mem[byp_slot[i]];
    end
  end
`endif

endmodule

// File: rtl/riscv_core_result_buffer.sv
// Result buffer between execution pipes, ROB and RF: captures results, issues finish marks, drives RF writes.
// Optional same-cycle operand bypass is built when RESULT_BYPASS_EN is defined.
module riscv_core_result_buffer
  import riscv_core_rob_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        cmpl_val_A,
  input  slot_t       cmpl_slot_A,
  input  data_t       cmpl_data_A,
  input  logic        cmpl_val_B,
  input  slot_t       cmpl_slot_B,
  input  data_t       cmpl_data_B,
  output logic        rob_cmpl_req_A,
  output slot_t       rob_cmpl_slot_A,
  output logic        rob_cmpl_req_B,
  output slot_t       rob_cmpl_slot_B,
  input  logic        rob_ready_A,
  input  slot_t       rob_slot_A,
  input  reg_t        rob_rdaddr_A,
  input  logic        rob_wen_A,
  input  logic        rob_ready_B,
  input  slot_t       rob_slot_B,
  input  reg_t        rob_rdaddr_B,
  input  logic        rob_wen_B,
  output logic        rf_wen_A,
  output reg_t        rf_waddr_A,
  output data_t       rf_wdata_A,
  output logic        rf_wen_B,
  output reg_t        rf_waddr_B,
  output data_t       rf_wdata_B,
  input  slot_t       byp_slot_0,
  input  slot_t       byp_slot_1,
  input  slot_t       byp_slot_2,
  input  slot_t       byp_slot_3,
  output logic        byp_hit_0,
  output logic        byp_hit_1,
  output logic        byp_hit_2,
  output logic        byp_hit_3,
  output data_t       byp_data_0,
  output data_t       byp_data_1,
  output data_t       byp_data_2,
  output data_t       byp_data_3,
  output logic [31:0] retire_count,
  output logic        dup_cmpl_err
);

  logic  dup;
  logic  commit_b;
  data_t rd_data_a, rd_data_b;
  logic  rd_vld_a, rd_vld_b;

  logic        req_a_q, req_a_d, req_b_q, req_b_d;
  slot_t       slot_a_q, slot_a_d, slot_b_q, slot_b_d;
  logic        rf_wen_a_q, rf_wen_a_d, rf_wen_b_q, rf_wen_b_d;
  reg_t        rf_waddr_a_q, rf_waddr_a_d, rf_waddr_b_q, rf_waddr_b_d;
  data_t       rf_wdata_a_q, rf_wdata_a_d, rf_wdata_b_q, rf_wdata_b_d;
  logic [31:0] retire_q, retire_d;
  logic        dup_err_q, dup_err_d;

  assign dup      = cmpl_val_A && cmpl_val_B && (cmpl_slot_A == cmpl_slot_B);
  // B commits only behind A: the ROB retires in order
  assign commit_b = rob_ready_A && rob_ready_B;

`ifdef RESULT_BYPASS_EN
  slot_t byp_slot [4];
  logic  ram_byp_vld  [4];
  data_t ram_byp_data [4];
  logic  byp_hit  [4];
  data_t byp_data [4];

  assign byp_slot[0] = byp_slot_0;
  assign byp_slot[1] = byp_slot_1;
  assign byp_slot[2] = byp_slot_2;
  assign byp_slot[3] = byp_slot_3;
`endif

  riscv_core_result_buffer_ram u_ram (
    .clk        (clk),
    .reset      (reset),
    .wr_en_a    (cmpl_val_A),
    .wr_slot_a  (cmpl_slot_A),
    .wr_data_a  (cmpl_data_A),
    .wr_en_b    (cmpl_val_B && !dup),
    .wr_slot_b  (cmpl_slot_B),
    .wr_data_b  (cmpl_data_B),
    .clr_en_a   (rob_ready_A),
    .clr_slot_a (rob_slot_A),
    .clr_en_b   (commit_b),
    .clr_slot_b (rob_slot_B),
    .rd_slot_a  (rob_slot_A),
    .rd_data_a  (rd_data_a),
    .rd_vld_a   (rd_vld_a),
    .rd_slot_b  (rob_slot_B),
    .rd_data_b  (rd_data_b),
    .rd_vld_b   (rd_vld_b)
`ifdef RESULT_BYPASS_EN
    ,
    .byp_slot   (byp_slot),
    .byp_vld    (ram_byp_vld),
    .byp_data   (ram_byp_data)
`endif
  );

  always_comb begin
    req_a_d      = cmpl_val_A;
    slot_a_d     = cmpl_slot_A;
    req_b_d      = cmpl_val_B && !dup;
    slot_b_d     = cmpl_slot_B;
    // Empty slots (squashed or never completed) retire without touching the RF
    rf_wen_a_d   = rob_ready_A && rob_wen_A && (rob_rdaddr_A != '0) && rd_vld_a;
    rf_waddr_a_d = rob_ready_A ? rob_rdaddr_A : rf_waddr_a_q;
    rf_wdata_a_d = rob_ready_A ? rd_data_a    : rf_wdata_a_q;
    rf_wen_b_d   = commit_b && rob_wen_B && (rob_rdaddr_B != '0) && rd_vld_b;
    rf_waddr_b_d = commit_b ? rob_rdaddr_B : rf_waddr_b_q;
    rf_wdata_b_d = commit_b ? rd_data_b    : rf_wdata_b_q;
    retire_d     = retire_q + 32'(rob_ready_A) + 32'(commit_b);
    dup_err_d    = dup_err_q || dup;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      req_a_q      <= 1'b0;
      slot_a_q     <= '0;
      req_b_q      <= 1'b0;
      slot_b_q     <= '0;
      rf_wen_a_q   <= 1'b0;
      rf_waddr_a_q <= '0;
      rf_wdata_a_q <= '0;
      rf_wen_b_q   <= 1'b0;
      rf_waddr_b_q <= '0;
      rf_wdata_b_q <= '0;
      retire_q     <= '0;
      dup_err_q    <= 1'b0;
    end else begin
      req_a_q      <= req_a_d;
      slot_a_q     <= slot_a_d;
      req_b_q      <= req_b_d;
      slot_b_q     <= slot_b_d;
      rf_wen_a_q   <= rf_wen_a_d;
      rf_waddr_a_q <= rf_waddr_a_d;
      rf_wdata_a_q <= rf_wdata_a_d;
      rf_wen_b_q   <= rf_wen_b_d;
      rf_waddr_b_q <= rf_waddr_b_d;
      rf_wdata_b_q <= rf_wdata_b_d;
      retire_q     <= retire_d;
      dup_err_q    <= dup_err_d;
    end
  end

  assign rob_cmpl_req_A  = req_a_q;
  assign rob_cmpl_slot_A = slot_a_q;
  assign rob_cmpl_req_B  = req_b_q;
  assign rob_cmpl_slot_B = slot_b_q;
  assign rf_wen_A        = rf_wen_a_q;
  assign rf_waddr_A      = rf_waddr_a_q;
  assign rf_wdata_A      = rf_wdata_a_q;
  assign rf_wen_B        = rf_wen_b_q;
  assign rf_waddr_B      = rf_waddr_b_q;
  assign rf_wdata_B      = rf_wdata_b_q;
  assign retire_count    = retire_q;
  assign dup_cmpl_err    = dup_err_q;

`ifdef RESULT_BYPASS_EN
  // In-flight completions forward ahead of stored data; pipe A is the more recent writer
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      byp_hit[i]  = 1'b0;
      byp_data[i] = '0;
      if (cmpl_val_A && (cmpl_slot_A == byp_slot[i])) begin
        byp_hit[i]  = 1'b1;
        byp_data[i] = cmpl_data_A;
      end else if (cmpl_val_B && (cmpl_slot_B == byp_slot[i])) begin
        byp_hit[i]  = 1'b1;
        byp_data[i] = cmpl_data_B;
      end else if (ram_byp_vld[i]) begin
        byp_hit[i]  = 1'b1;
        byp_data[i] = ram_byp_data[i];
      end
    end
  end

  assign byp_hit_0  = byp_hit[0];
  assign byp_hit_1  = byp_hit[1];
  assign byp_hit_2  = byp_hit[2];
  assign byp_hit_3  = byp_hit[3];
  assign byp_data_0 = byp_data[0];
  assign byp_data_1 = byp_data[1];
  assign byp_data_2 = byp_data[2];
  assign byp_data_3 = byp_data[3];
`else
  logic unused_byp_slots;
  assign unused_byp_slots = ^{byp_slot_0, byp_slot_1, byp_slot_2, byp_slot_3};

  assign byp_hit_0  = 1'b0;
  assign byp_hit_1  = 1'b0;
  assign byp_hit_2  = 1'b0;
  assign byp_hit_3  = 1'b0;
  assign byp_data_0 = '0;
  assign byp_data_1 = '0;
  assign byp_data_2 = '0;
  assign byp_data_3 = '0;
`endif

endmodule

// File: tb/tb_riscv_core_result_buffer.sv
// Bench for riscv_core_result_buffer: directed vector table, hand sequences and a slot-level reference model.
module tb_riscv_core_result_buffer;
  import riscv_core_rob_pkg::*;

`ifdef RESULT_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed {
    logic  rst;
    logic  va;  slot_t sa;  data_t da;
    logic  vb;  slot_t sb;  data_t db;
    logic  ra;  slot_t rsa; reg_t rda; logic wa;
    logic  rb;  slot_t rsb; reg_t rdb; logic wb;
    slot_t bs0; slot_t bs1; slot_t bs2; slot_t bs3;
  } in_t;

  typedef struct packed {
    in_t         in;
    logic        e_req_a;
    slot_t       e_slot_a;
    logic        e_req_b;
    logic        e_wen_a;
    data_t       e_wdata_a;
    logic        e_wen_b;
    data_t       e_wdata_b;
    logic [31:0] e_ret;
    logic        e_dup;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  logic cmpl_val_A, cmpl_val_B, rob_ready_A, rob_ready_B, rob_wen_A, rob_wen_B;
  slot_t cmpl_slot_A, cmpl_slot_B, rob_slot_A, rob_slot_B;
  data_t cmpl_data_A, cmpl_data_B;
  reg_t  rob_rdaddr_A, rob_rdaddr_B;
  slot_t byp_slot_0, byp_slot_1, byp_slot_2, byp_slot_3;
  logic  rob_cmpl_req_A, rob_cmpl_req_B, rf_wen_A, rf_wen_B, dup_cmpl_err;
  slot_t rob_cmpl_slot_A, rob_cmpl_slot_B;
  reg_t  rf_waddr_A, rf_waddr_B;
  data_t rf_wdata_A, rf_wdata_B;
  logic  byp_hit_0, byp_hit_1, byp_hit_2, byp_hit_3;
  data_t byp_data_0, byp_data_1, byp_data_2, byp_data_3;
  logic [31:0] retire_count;

  riscv_core_result_buffer dut (
    .clk(clk), .reset(reset),
    .cmpl_val_A(cmpl_val_A), .cmpl_slot_A(cmpl_slot_A), .cmpl_data_A(cmpl_data_A),
    .cmpl_val_B(cmpl_val_B), .cmpl_slot_B(cmpl_slot_B), .cmpl_data_B(cmpl_data_B),
    .rob_cmpl_req_A(rob_cmpl_req_A), .rob_cmpl_slot_A(rob_cmpl_slot_A),
    .rob_cmpl_req_B(rob_cmpl_req_B), .rob_cmpl_slot_B(rob_cmpl_slot_B),
    .rob_ready_A(rob_ready_A), .rob_slot_A(rob_slot_A), .rob_rdaddr_A(rob_rdaddr_A), .rob_wen_A(rob_wen_A),
    .rob_ready_B(rob_ready_B), .rob_slot_B(rob_slot_B), .rob_rdaddr_B(rob_rdaddr_B), .rob_wen_B(rob_wen_B),
    .rf_wen_A(rf_wen_A), .rf_waddr_A(rf_waddr_A), .rf_wdata_A(rf_wdata_A),
    .rf_wen_B(rf_wen_B), .rf_waddr_B(rf_waddr_B), .rf_wdata_B(rf_wdata_B),
    .byp_slot_0(byp_slot_0), .byp_slot_1(byp_slot_1), .byp_slot_2(byp_slot_2), .byp_slot_3(byp_slot_3),
    .byp_hit_0(byp_hit_0), .byp_hit_1(byp_hit_1), .byp_hit_2(byp_hit_2), .byp_hit_3(byp_hit_3),
    .byp_data_0(byp_data_0), .byp_data_1(byp_data_1), .byp_data_2(byp_data_2), .byp_data_3(byp_data_3),
    .retire_count(retire_count), .dup_cmpl_err(dup_cmpl_err)
  );

  always #5 clk = ~clk;

  int n_run  = 0;
  int n_fail = 0;

  // Reference model: per-slot contents plus expected registered outputs
  logic        m_vld  [NUM_SLOTS];
  data_t       m_data [NUM_SLOTS];
  logic        e_req_a, e_req_b, e_wen_a, e_wen_b, e_dup;
  slot_t       e_slot_a, e_slot_b;
  reg_t        e_waddr_a, e_waddr_b;
  data_t       e_wdata_a, e_wdata_b;
  logic [31:0] e_ret;

  vec_t tbl [11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic slot_t get_bs(in_t v, int i);
    case (i)
      0: return v.bs0;
      1: return v.bs1;
      2: return v.bs2;
      default: return v.bs3;
    endcase
  endfunction

  function automatic logic get_hit(int i);
    case (i)
      0: return byp_hit_0;
      1: return byp_hit_1;
      2: return byp_hit_2;
      default: return byp_hit_3;
    endcase
  endfunction

  function automatic data_t get_bdata(int i);
    case (i)
      0: return byp_data_0;
      1: return byp_data_1;
      2: return byp_data_2;
      default: return byp_data_3;
    endcase
  endfunction

  function automatic in_t with_ca(in_t v, slot_t s, data_t d);
    v.va = 1'b1; v.sa = s; v.da = d; return v;
  endfunction
  function automatic in_t with_cb(in_t v, slot_t s, data_t d);
    v.vb = 1'b1; v.sb = s; v.db = d; return v;
  endfunction
  function automatic in_t with_ra(in_t v, slot_t s, reg_t rd, logic w);
    v.ra = 1'b1; v.rsa = s; v.rda = rd; v.wa = w; return v;
  endfunction
  function automatic in_t with_rb(in_t v, slot_t s, reg_t rd, logic w);
    v.rb = 1'b1; v.rsb = s; v.rdb = rd; v.wb = w; return v;
  endfunction

  function automatic vec_t mkv(in_t v, logic rqa, slot_t sa, logic rqb, logic wa, data_t da,
                               logic wb, data_t db, logic [31:0] ret, logic dp);
    vec_t t;
    t.in = v; t.e_req_a = rqa; t.e_slot_a = sa; t.e_req_b = rqb;
    t.e_wen_a = wa; t.e_wdata_a = da; t.e_wen_b = wb; t.e_wdata_b = db;
    t.e_ret = ret; t.e_dup = dp;
    return t;
  endfunction

  task automatic drive(input in_t v);
    reset        = v.rst;
    cmpl_val_A   = v.va;  cmpl_slot_A = v.sa;  cmpl_data_A = v.da;
    cmpl_val_B   = v.vb;  cmpl_slot_B = v.sb;  cmpl_data_B = v.db;
    rob_ready_A  = v.ra;  rob_slot_A  = v.rsa; rob_rdaddr_A = v.rda; rob_wen_A = v.wa;
    rob_ready_B  = v.rb;  rob_slot_B  = v.rsb; rob_rdaddr_B = v.rdb; rob_wen_B = v.wb;
    byp_slot_0   = v.bs0; byp_slot_1  = v.bs1; byp_slot_2  = v.bs2; byp_slot_3  = v.bs3;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_SLOTS; i++) m_vld[i] = 1'b0;
    e_req_a = 0; e_req_b = 0; e_wen_a = 0; e_wen_b = 0; e_dup = 0;
    e_slot_a = '0; e_slot_b = '0; e_waddr_a = '0; e_waddr_b = '0;
    e_wdata_a = '0; e_wdata_b = '0; e_ret = '0;
  endtask

  // Called one time unit after a rising edge: drive, then check combinational bypass
  task automatic apply_comb(input in_t v);
    slot_t s;
    logic  fa, fb, eh;
    data_t ed;
    drive(v);
    #1;
    for (int i = 0; i < 4; i++) begin
      s  = get_bs(v, i);
      fa = v.va && (v.sa == s);
      fb = v.vb && (v.sb == s);
      eh = BYP && (m_vld[s] || fa || fb);
      ed = fa ? v.da : (fb ? v.db : m_data[s]);
      chk($sformatf("byp_hit_%0d", i), 32'(get_hit(i)), 32'(eh));
      if (eh || !BYP) chk($sformatf("byp_data_%0d", i), get_bdata(i), BYP ? ed : '0);
    end
  endtask

  task automatic finish_edge(input in_t v);
    logic dp;
    @(posedge clk);
    if (v.rst) begin
      model_reset();
    end else begin
      dp       = v.va && v.vb && (v.sa == v.sb);
      e_req_a  = v.va;  e_slot_a = v.sa;
      e_req_b  = v.vb && !dp;  e_slot_b = v.sb;
      e_wen_a  = 1'b0;
      e_wen_b  = 1'b0;
      if (v.ra) begin
        e_wen_a = v.wa && (v.rda != 0) && m_vld[v.rsa];
        e_waddr_a = v.rda; e_wdata_a = m_data[v.rsa];
      end
      if (v.ra && v.rb) begin
        e_wen_b = v.wb && (v.rdb != 0) && m_vld[v.rsb];
        e_waddr_b = v.rdb; e_wdata_b = m_data[v.rsb];
      end
      e_ret = e_ret + (v.ra ? 1 : 0) + ((v.ra && v.rb) ? 1 : 0);
      e_dup = e_dup || dp;
      if (v.ra) m_vld[v.rsa] = 1'b0;
      if (v.ra && v.rb) m_vld[v.rsb] = 1'b0;
      if (v.vb) begin m_vld[v.sb] = 1'b1; m_data[v.sb] = v.db; end
      if (v.va) begin m_vld[v.sa] = 1'b1; m_data[v.sa] = v.da; end
    end
    #1;
    chk("rob_cmpl_req_A", 32'(rob_cmpl_req_A), 32'(e_req_a));
    if (e_req_a) chk("rob_cmpl_slot_A", 32'(rob_cmpl_slot_A), 32'(e_slot_a));
    chk("rob_cmpl_req_B", 32'(rob_cmpl_req_B), 32'(e_req_b));
    if (e_req_b) chk("rob_cmpl_slot_B", 32'(rob_cmpl_slot_B), 32'(e_slot_b));
    chk("rf_wen_A", 32'(rf_wen_A), 32'(e_wen_a));
    if (e_wen_a) begin
      chk("rf_waddr_A", 32'(rf_waddr_A), 32'(e_waddr_a));
      chk("rf_wdata_A", rf_wdata_A, e_wdata_a);
    end
    chk("rf_wen_B", 32'(rf_wen_B), 32'(e_wen_b));
    if (e_wen_b) begin
      chk("rf_waddr_B", 32'(rf_waddr_B), 32'(e_waddr_b));
      chk("rf_wdata_B", rf_wdata_B, e_wdata_b);
    end
    chk("retire_count", retire_count, e_ret);
    chk("dup_cmpl_err", 32'(dup_cmpl_err), 32'(e_dup));
  endtask

  task automatic run_cycle(input in_t v);
    apply_comb(v);
    finish_edge(v);
  endtask

  initial begin
    in_t I, v;
    I = '0;

    // Reset and idle
    v = I; v.rst = 1'b1;
    drive(v);
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    run_cycle(v);
    chk("reset rf_wdata_A", rf_wdata_A, 32'h0);
    chk("reset rf_waddr_B", 32'(rf_waddr_B), 32'h0);
    for (int i = 0; i < 10; i++) run_cycle(I);
    chk("idle retire_count", retire_count, 32'h0);
    chk("idle rf_wen_A", 32'(rf_wen_A), 32'h0);

    // Directed vector table
    tbl[0]  = mkv(with_ca(I, 5'd3, 32'hDEADBEEF),            1, 5'd3, 0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mkv(I,                                         0, 5'd0, 0, 0, 0, 0, 0, 0, 0);
    tbl[2]  = mkv(with_ra(I, 5'd3, 5'd7, 1),                 0, 5'd0, 0, 1, 32'hDEADBEEF, 0, 0, 1, 0);
    tbl[3]  = mkv(with_cb(with_ca(I, 5'd30, 32'h1E), 5'd31, 32'h1F), 1, 5'd30, 1, 0, 0, 0, 0, 1, 0);
    tbl[4]  = mkv(I,                                         0, 5'd0, 0, 0, 0, 0, 0, 1, 0);
    tbl[5]  = mkv(with_rb(with_ra(I, 5'd30, 5'd10, 1), 5'd31, 5'd11, 1), 0, 5'd0, 0, 1, 32'h1E, 1, 32'h1F, 3, 0);
    tbl[6]  = mkv(with_ca(I, slot_inc(5'd31), 32'h100),      1, 5'd0, 0, 0, 0, 0, 0, 3, 0);
    tbl[7]  = mkv(with_cb(with_ca(I, 5'd5, 32'h11), 5'd5, 32'h22), 1, 5'd5, 0, 0, 0, 0, 0, 3, 1);
    tbl[8]  = mkv(with_ra(I, 5'd5, 5'd12, 1),                0, 5'd0, 0, 1, 32'h11, 0, 0, 4, 1);
    tbl[9]  = mkv(with_rb(with_ra(I, 5'd9, 5'd14, 0), 5'd0, 5'd0, 1), 0, 5'd0, 0, 0, 0, 0, 0, 6, 1);
    tbl[10] = mkv(with_rb(I, 5'd1, 5'd15, 1),                0, 5'd0, 0, 0, 0, 0, 0, 6, 1);

    for (int i = 0; i < 11; i++) begin
      run_cycle(tbl[i].in);
      chk($sformatf("tbl%0d req_A", i), 32'(rob_cmpl_req_A), 32'(tbl[i].e_req_a));
      if (tbl[i].e_req_a) chk($sformatf("tbl%0d slot_A", i), 32'(rob_cmpl_slot_A), 32'(tbl[i].e_slot_a));
      chk($sformatf("tbl%0d req_B", i), 32'(rob_cmpl_req_B), 32'(tbl[i].e_req_b));
      chk($sformatf("tbl%0d wen_A", i), 32'(rf_wen_A), 32'(tbl[i].e_wen_a));
      if (tbl[i].e_wen_a) chk($sformatf("tbl%0d wdata_A", i), rf_wdata_A, tbl[i].e_wdata_a);
      chk($sformatf("tbl%0d wen_B", i), 32'(rf_wen_B), 32'(tbl[i].e_wen_b));
      if (tbl[i].e_wen_b) chk($sformatf("tbl%0d wdata_B", i), rf_wdata_B, tbl[i].e_wdata_b);
      chk($sformatf("tbl%0d retire", i), retire_count, tbl[i].e_ret);
      chk($sformatf("tbl%0d dup", i), 32'(dup_cmpl_err), 32'(tbl[i].e_dup));
    end

    // Bypass hit from same-cycle completion, held until commit
    v = with_ca(I, 5'd4, 32'h55); v.bs0 = 5'd4;
    apply_comb(v);
    chk("byp same-cycle hit", 32'(byp_hit_0), BYP ? 32'h1 : 32'h0);
    chk("byp same-cycle data", byp_data_0, BYP ? 32'h55 : 32'h0);
    finish_edge(v);
    v = I; v.bs0 = 5'd4;
    apply_comb(v);
    chk("byp held hit", 32'(byp_hit_0), BYP ? 32'h1 : 32'h0);
    chk("byp held data", byp_data_0, BYP ? 32'h55 : 32'h0);
    finish_edge(v);
    v = with_ra(I, 5'd4, 5'd13, 1); v.bs0 = 5'd4;
    run_cycle(v);
    chk("byp commit wdata_A", rf_wdata_A, 32'h55);
    v = I; v.bs0 = 5'd4;
    apply_comb(v);
    chk("byp after commit hit", 32'(byp_hit_0), 32'h0);
    finish_edge(v);

    // Reset mid-stream drops pending marks and buffered results
    v = with_ca(I, 5'd6, 32'h66); v.bs1 = 5'd6;
    run_cycle(v);
    chk("pre-reset mark", 32'(rob_cmpl_req_A), 32'h1);
    v = with_ca(I, 5'd7, 32'h77); v.rst = 1'b1; v.bs1 = 5'd6;
    run_cycle(v);
    chk("reset drops mark", 32'(rob_cmpl_req_A), 32'h0);
    chk("reset retire", retire_count, 32'h0);
    chk("reset dup", 32'(dup_cmpl_err), 32'h0);
    v = I; v.bs1 = 5'd6; v.bs2 = 5'd7;
    apply_comb(v);
    chk("reset clears hit 6", 32'(byp_hit_1), 32'h0);
    chk("reset clears hit 7", 32'(byp_hit_2), 32'h0);
    finish_edge(v);

    // Randomized traffic over a narrow slot range to force collisions and wrap reuse
    for (int n = 0; n < 500; n++) begin
      v = I;
      v.rst = ($urandom_range(0, 99) == 0);
      v.va  = $urandom_range(0, 1);  v.sa = slot_t'($urandom_range(0, 7));  v.da = $urandom;
      v.vb  = $urandom_range(0, 1);  v.sb = slot_t'($urandom_range(0, 7));  v.db = $urandom;
      v.ra  = $urandom_range(0, 1);  v.rsa = slot_t'($urandom_range(0, 7));
      v.rda = reg_t'($urandom_range(0, 3)); v.wa = ($urandom_range(0, 3) != 0);
      v.rb  = $urandom_range(0, 1);  v.rsb = slot_t'($urandom_range(0, 7));
      v.rdb = reg_t'($urandom_range(0, 3)); v.wb = ($urandom_range(0, 3) != 0);
      v.bs0 = slot_t'($urandom_range(0, 7)); v.bs1 = slot_t'($urandom_range(0, 7));
      v.bs2 = slot_t'($urandom_range(0, 7)); v.bs3 = slot_t'($urandom_range(0, 31));
      run_cycle(v);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
